// File: rtl/counter_test_pkg.sv
// Shared types and defaults for the counter stimulus/checker block.
package counter_test_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_IDLE = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_RST_CYCLES  = 2;
    localparam int DEF_IDLE_CYCLES = 3;
    localparam int DEF_RUN_CYCLES  = 100;
    localparam int DEF_GAP_PERIOD  = 0;
    localparam int DEF_ERR_W       = 8;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/counter_ref_model.sv
// Expected-count register: follows the counter's reset/enable inputs exactly
// like a correct counter would, giving the value it must return.
module counter_ref_model
    import counter_test_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dut_reset,
    input  logic             dut_enable,
    output logic [WIDTH-1:0] exp
);

    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_d;

    always_comb begin
        exp_d = exp_q;
        if (dut_reset) begin
            exp_d = '0;
        end else if (dut_enable) begin
            exp_d = exp_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q <= '0;
        end else begin
            exp_q <= exp_d;
        end
    end

    assign exp = exp_q;

endmodule

// File: rtl/counter_stim_checker.sv
// On-chip stimulus generator and checker for an up-counter: sequences reset,
// idle and run phases, predicts the count and records mismatches.
module counter_stim_checker
    import counter_test_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int RUN_CYCLES  = DEF_RUN_CYCLES,
    parameter int GAP_PERIOD  = DEF_GAP_PERIOD,
    parameter int ERR_W       = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    output logic             dut_reset,
    output logic             dut_enable,
    input  logic [WIDTH-1:0] dut_count,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
);

    localparam int MAX_PH = (RUN_CYCLES > RST_CYCLES)
                          ? ((RUN_CYCLES > IDLE_CYCLES) ? RUN_CYCLES : IDLE_CYCLES)
                          : ((RST_CYCLES > IDLE_CYCLES) ? RST_CYCLES : IDLE_CYCLES);
    localparam int CNT_W  = (MAX_PH < 2) ? 1 : $clog2(MAX_PH + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [31:0]      GAP_DIV   = (GAP_PERIOD > 0) ? 32'(GAP_PERIOD) : 32'd1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dut_reset_q, dut_reset_d;
    logic             dut_enable_q, dut_enable_d;
    logic             done_q, done_d;
    logic             check_en_q, check_en_d;
    logic             fail_q, fail_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;
    logic [WIDTH-1:0] first_got_q, first_got_d;
    logic [WIDTH-1:0] exp_val;
    logic [31:0]      run_idx;
    logic             gap_hit;
    logic             mismatch;

    counter_ref_model #(
        .WIDTH(WIDTH)
    ) u_ref (
        .clk       (clk),
        .reset     (reset),
        .dut_reset (dut_reset_q),
        .dut_enable(dut_enable_q),
        .exp       (exp_val)
    );

    // Sequencer; the counter outputs are decoded from the next state so the
    // registered versions line up with state_q/cnt_q.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   if (cnt_q == RST_LAST) state_d = (IDLE_CYCLES == 0) ? S_RUN : S_IDLE;
            S_IDLE:  if (cnt_q == IDLE_LAST) state_d = S_RUN;
            S_RUN:   if (cnt_q == RUN_LAST) state_d = S_DONE;
            default: state_d = S_DONE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_DONE) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        run_idx      = 32'(cnt_d) + 32'd1;
        gap_hit      = (GAP_PERIOD > 0) && ((run_idx % GAP_DIV) == 32'd0);
        dut_reset_d  = (state_d == S_RST);
        dut_enable_d = (state_d == S_RUN) && !gap_hit;
        done_d       = (state_d == S_DONE);
    end

    // Checking starts once the counter has seen its reset released.
    always_comb begin
        check_en_d  = check_en_q | ~dut_reset_q;
        mismatch    = check_en_q && (dut_count != exp_val);
        fail_d      = fail_q | mismatch;
        err_cnt_d   = err_cnt_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        if (mismatch) begin
            err_cnt_d = ERR_W'(sat_inc(32'(err_cnt_q), ERR_W));
            if (!fail_q) begin
                first_exp_d = exp_val;
                first_got_d = dut_count;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_RST;
            cnt_q        <= '0;
            dut_reset_q  <= 1'b1;
            dut_enable_q <= 1'b0;
            done_q       <= 1'b0;
            check_en_q   <= 1'b0;
            fail_q       <= 1'b0;
            err_cnt_q    <= '0;
            first_exp_q  <= '0;
            first_got_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dut_reset_q  <= dut_reset_d;
            dut_enable_q <= dut_enable_d;
            done_q       <= done_d;
            check_en_q   <= check_en_d;
            fail_q       <= fail_d;
            err_cnt_q    <= err_cnt_d;
            first_exp_q  <= first_exp_d;
            first_got_q  <= first_got_d;
        end
    end

    assign dut_reset  = dut_reset_q;
    assign dut_enable = dut_enable_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign pass       = done_q & ~fail_q;
    assign err_cnt    = err_cnt_q;
    assign first_exp  = first_exp_q;
    assign first_got  = first_got_q;

endmodule
